// File: rtl/blinky_rgb.sv
// Free-running RGB LED pattern generator: counter bits select the colour,
// a fixed-duty PWM dims each lit channel, and the pins are active-low.
module blinky_rgb #(
  parameter int CNT_WIDTH = 24,
  parameter int BASE_BIT  = 21,
  parameter int PWM_BITS  = 8,
  parameter int DUTY      = 64
) (
  input  logic clk_25m,
  input  logic rst,
  output logic led_r,
  output logic led_g,
  output logic led_b
);

  localparam int PW = PWM_BITS + 1;

  // One extra bit lets DUTY = 2^PWM_BITS compare as always-on.
  function automatic logic pwm_gate(input logic [PWM_BITS-1:0] phase);
    logic [PW-1:0] phase_ext;
    logic [PW-1:0] duty_ext;
    phase_ext = {1'b0, phase};
    duty_ext  = PW'(DUTY);
    return phase_ext < duty_ext;
  endfunction

  logic [CNT_WIDTH-1:0] cnt;
  logic [2:0]           colour;
  logic                 pwm_on;
  logic [2:0]           lit;
  logic                 unused_cnt_bits;

  assign colour = cnt[BASE_BIT+2:BASE_BIT];
  assign pwm_on = pwm_gate(cnt[PWM_BITS-1:0]);
  assign lit    = colour & {3{pwm_on}};

  // Middle counter bits only set the step length.
  assign unused_cnt_bits = ^cnt;

  // Stage p0 -> p1: counter value registered onto the LED pins
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      cnt                   <= '0;
      {led_b, led_g, led_r} <= 3'b111;
    end else begin
      cnt                   <= cnt + 1'b1;
      {led_b, led_g, led_r} <= ~lit;
    end
  end

endmodule

// File: tb/tb_blinky_rgb.sv
// Directed bench for blinky_rgb: default-parameter reset check plus three
// reduced-parameter instances (duty 4/4, 1/4, 0/4) sharing one reset.
module tb_blinky_rgb;

  logic clk_25m = 1'b0;
  logic rst     = 1'b1;
  logic rst_def = 1'b1;

  logic def_r, def_g, def_b;
  logic d4_r, d4_g, d4_b;
  logic d1_r, d1_g, d1_b;
  logic d0_r, d0_g, d0_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk_25m = ~clk_25m;

  blinky_rgb dut_def (
    .clk_25m(clk_25m), .rst(rst_def), .led_r(def_r), .led_g(def_g), .led_b(def_b)
  );
  blinky_rgb #(.CNT_WIDTH(7), .BASE_BIT(4), .PWM_BITS(2), .DUTY(4)) dut_d4 (
    .clk_25m(clk_25m), .rst(rst), .led_r(d4_r), .led_g(d4_g), .led_b(d4_b)
  );
  blinky_rgb #(.CNT_WIDTH(7), .BASE_BIT(4), .PWM_BITS(2), .DUTY(1)) dut_d1 (
    .clk_25m(clk_25m), .rst(rst), .led_r(d1_r), .led_g(d1_g), .led_b(d1_b)
  );
  blinky_rgb #(.CNT_WIDTH(7), .BASE_BIT(4), .PWM_BITS(2), .DUTY(0)) dut_d0 (
    .clk_25m(clk_25m), .rst(rst), .led_r(d0_r), .led_g(d0_g), .led_b(d0_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25m);
    @(negedge clk_25m);
  endtask

  // Pin pattern {b,g,r} for a reduced instance whose registered count was c.
  function automatic logic [2:0] exp_pins(input int c, input int duty);
    int cc;
    logic [2:0] col;
    logic on;
    cc  = c % 128;
    col = 3'((cc >> 4) & 7);
    on  = (cc % 4) < duty;
    return ~(col & {3{on}});
  endfunction

  // Hand-computed {b,g,r} pins of the DUTY=4 instance after k edges from release.
  typedef struct { int k; logic [2:0] pins; } vec_t;
  vec_t vecs[8] = '{
    '{1,   3'b111}, '{16,  3'b111}, '{17,  3'b110}, '{33,  3'b101},
    '{49,  3'b100}, '{113, 3'b000}, '{128, 3'b000}, '{129, 3'b111}
  };

  initial begin
    int vi;
    vi = 0;
    repeat (3) @(posedge clk_25m);
    @(negedge clk_25m);
    check_eq("rst_def_leds", {29'd0, def_b, def_g, def_r}, 32'h7);
    check_eq("rst_d4_leds",  {29'd0, d4_b, d4_g, d4_r}, 32'h7);
    check_eq("rst_d4_cnt",   32'(dut_d4.cnt), 32'd0);
    check_eq("rst_def_cnt",  32'(dut_def.cnt), 32'd0);
    rst     = 1'b0;
    rst_def = 1'b0;

    for (int k = 1; k <= 2500; k++) begin
      tick();
      check_eq("def_leds_off", {29'd0, def_b, def_g, def_r}, 32'h7);
      if (k <= 140) begin
        check_eq("d1_pwm", {29'd0, d1_b, d1_g, d1_r}, {29'd0, exp_pins(k - 1, 1)});
        check_eq("d0_off", {29'd0, d0_b, d0_g, d0_r}, 32'h7);
      end
      if (vi < 8 && vecs[vi].k == k) begin
        check_eq($sformatf("d4_seq_k%0d", k), {29'd0, d4_b, d4_g, d4_r}, {29'd0, vecs[vi].pins});
        vi++;
      end
    end
    check_eq("def_cnt_2500", 32'(dut_def.cnt), 32'd2500);

    // Reduced count is now 2500 mod 128 = 68; 16 more cycles lands at 84 (colour 101).
    repeat (16) tick();
    check_eq("d4_colour5", {29'd0, d4_b, d4_g, d4_r}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_d4_leds", {29'd0, d4_b, d4_g, d4_r}, 32'h7);
    check_eq("midrst_d1_leds", {29'd0, d1_b, d1_g, d1_r}, 32'h7);
    check_eq("midrst_d4_cnt",  32'(dut_d4.cnt), 32'd0);
    for (int j = 1; j <= 17; j++) begin
      tick();
      check_eq($sformatf("restart_j%0d", j), {29'd0, d4_b, d4_g, d4_r},
               (j == 17) ? 32'h6 : 32'h7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
